// File: rtl/order_book_pkg.sv
// ============================================================================
// Module      : order_book_pkg
// Description : Shared command types and one-hot request encodings for the
//               order-book request path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package order_book_pkg;

    localparam int ID_W    = 32;
    localparam int QTY_W   = 32;
    localparam int PRICE_W = 64;

    typedef enum logic [1:0] {
        CMD_ADD      = 2'd0,
        CMD_CANCEL   = 2'd1,
        CMD_DECREASE = 2'd2,
        CMD_ILLEGAL  = 2'd3
    } cmd_e;

    localparam logic [2:0] REQ_NONE     = 3'b000;
    localparam logic [2:0] REQ_ADD      = 3'b100;
    localparam logic [2:0] REQ_DELETE   = 3'b010;
    localparam logic [2:0] REQ_DECREASE = 3'b001;

    typedef struct packed {
        logic [ID_W-1:0]    order_id;
        logic [QTY_W-1:0]   quantity;
        logic [PRICE_W-1:0] price;
        cmd_e               cmd;
    } order_cmd_t;

    function automatic logic [2:0] req_type_of(input cmd_e cmd);
        case (cmd)
            CMD_ADD:      return REQ_ADD;
            CMD_CANCEL:   return REQ_DELETE;
            CMD_DECREASE: return REQ_DECREASE;
            default:      return REQ_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/order_cmd_fifo.sv
// ============================================================================
// Module      : order_cmd_fifo
// Description : Synchronous pointer-plus-count FIFO of order commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_cmd_fifo
    import order_book_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  order_cmd_t push_data,
    input  logic       pop,
    output order_cmd_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    order_cmd_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/order_request_issuer.sv
// ============================================================================
// Module      : order_request_issuer
// Description : Buffers decoded order commands and issues them one at a time
//               to the order book with busy/ready turnaround handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_request_issuer
    import order_book_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_cmd,
    input  logic [ID_W-1:0]    in_order_id,
    input  logic [QTY_W-1:0]   in_quantity,
    input  logic [PRICE_W-1:0] in_price,
    output logic               book_valid,
    output logic [2:0]         book_req_type,
    output logic [ID_W-1:0]    book_order_id,
    output logic [QTY_W-1:0]   book_quantity,
    output logic [PRICE_W-1:0] book_price,
    input  logic               book_ready,
    output logic               busy,
    output logic [31:0]        issued_count,
    output logic [CNT_W-1:0]   dropped_count,
    output logic [CNT_W-1:0]   timeout_count
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_BUSY  = 2'd2,
        ST_WAIT_READY = 2'd3
    } state_e;

    localparam int WAIT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_TIMEOUT - 1);

    state_e            state;
    state_e            state_nxt;
    logic              ready_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic              illegal_in;
    logic              push;
    logic              pop;
    logic              accept;
    logic              expire;
    logic              wait_inc;
    logic [WAIT_W-1:0] wait_cnt;
    order_cmd_t        in_entry;
    order_cmd_t        head;

    // ready_en keeps in_ready low until the first edge after reset release.
    assign in_ready   = ready_en && !fifo_full;
    assign illegal_in = (cmd_e'(in_cmd) == CMD_ILLEGAL);
    assign push       = in_valid && in_ready && !illegal_in;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    assign in_entry.order_id = in_order_id;
    assign in_entry.quantity = in_quantity;
    assign in_entry.price    = in_price;
    assign in_entry.cmd      = cmd_e'(in_cmd);

    order_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        accept    = 1'b0;
        expire    = 1'b0;
        wait_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (book_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!book_ready) begin
                    state_nxt = ST_WAIT_READY;
                end else if (wait_cnt == WAIT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (book_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en      <= 1'b0;
            book_valid    <= 1'b0;
            book_req_type <= REQ_NONE;
            book_order_id <= '0;
            book_quantity <= '0;
            book_price    <= '0;
            wait_cnt      <= '0;
            issued_count  <= '0;
            dropped_count <= '0;
            timeout_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (pop) begin
                book_valid    <= 1'b1;
                book_req_type <= req_type_of(head.cmd);
                book_order_id <= head.order_id;
                book_quantity <= (head.cmd == CMD_CANCEL) ? '0 : head.quantity;
                book_price    <= (head.cmd == CMD_ADD) ? head.price : '0;
            end
            if (accept) begin
                book_valid   <= 1'b0;
                issued_count <= issued_count + 32'd1;
                wait_cnt     <= '0;
            end
            if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
            if (expire && (timeout_count != '1))
                timeout_count <= timeout_count + CNT_W'(1);
            if (in_valid && in_ready && illegal_in && (dropped_count != '1))
                dropped_count <= dropped_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_order_request_issuer.sv
// ============================================================================
// Module      : tb_order_request_issuer
// Description : Randomized and directed bench for order_request_issuer against
//               a queue-based model of expected book transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_order_request_issuer;

    localparam int DEPTH = 8;

    localparam int MODE_REAL   = 0;  // book holds ready one cycle, then goes busy
    localparam int MODE_ALWAYS = 1;  // book_ready stuck high
    localparam int MODE_STALL  = 2;  // book_ready stuck low

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_cmd = 2'd0;
    logic [31:0] in_order_id = '0;
    logic [31:0] in_quantity = '0;
    logic [63:0] in_price = '0;
    logic        book_valid;
    logic [2:0]  book_req_type;
    logic [31:0] book_order_id;
    logic [31:0] book_quantity;
    logic [63:0] book_price;
    logic        book_ready = 1'b1;
    logic        busy;
    logic [31:0] issued_count;
    logic [15:0] dropped_count;
    logic [15:0] timeout_count;

    always #5 clk = ~clk;

    order_request_issuer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cmd        (in_cmd),
        .in_order_id   (in_order_id),
        .in_quantity   (in_quantity),
        .in_price      (in_price),
        .book_valid    (book_valid),
        .book_req_type (book_req_type),
        .book_order_id (book_order_id),
        .book_quantity (book_quantity),
        .book_price    (book_price),
        .book_ready    (book_ready),
        .busy          (busy),
        .issued_count  (issued_count),
        .dropped_count (dropped_count),
        .timeout_count (timeout_count)
    );

    typedef struct {
        logic [2:0]  rt;
        logic [31:0] id;
        logic [31:0] qty;
        logic [63:0] pr;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t prev_f;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_xfer = -100;
    int    n_xfer = 0;
    int    exp_issued = 0;
    int    exp_dropped = 0;
    int    exp_timeout = 0;
    int    mode = MODE_REAL;
    int    ph = 0;
    bit    xfer_now = 1'b0;
    bit    push_ok = 1'b0;
    bit    prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic xfer_t expect_of(input logic [1:0] c, input logic [31:0] id,
                                        input logic [31:0] qty, input logic [63:0] pr);
        xfer_t e;
        e.id = id;
        case (c)
            2'd0:    begin e.rt = 3'b100; e.qty = qty;   e.pr = pr;    end
            2'd1:    begin e.rt = 3'b010; e.qty = 32'd0; e.pr = 64'd0; end
            default: begin e.rt = 3'b001; e.qty = qty;   e.pr = 64'd0; end
        endcase
        return e;
    endfunction

    // Evaluated mid-cycle: decides what the coming rising edge will do.
    task automatic observe();
        xfer_t o;
        xfer_t e;
        xfer_now = 1'b0;
        push_ok  = 1'b0;
        o = '{book_req_type, book_order_id, book_quantity, book_price};
        if (prev_stall) begin
            check("hold_valid", book_valid, 1);
            check("hold_rt", o.rt, prev_f.rt);
            check("hold_id", o.id, prev_f.id);
            check("hold_qty", o.qty, prev_f.qty);
            check("hold_price", o.pr, prev_f.pr);
        end
        if (in_valid && in_ready) begin
            push_ok = 1'b1;
            if (in_cmd == 2'd3) begin
                exp_dropped++;
            end else begin
                exp_q.push_back(expect_of(in_cmd, in_order_id, in_quantity, in_price));
                exp_issued++;
            end
        end
        if (book_valid && book_ready) begin
            xfer_now = 1'b1;
            n_xfer++;
            check("spacing", (cyc - last_xfer >= 3), 1);
            last_xfer = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("req_type", o.rt, e.rt);
                check("order_id", o.id, e.id);
                check("quantity", o.qty, e.qty);
                check("price", o.pr, e.pr);
            end
        end
        prev_stall = book_valid && !book_ready;
        prev_f     = o;
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            MODE_ALWAYS: book_ready = 1'b1;
            MODE_STALL:  book_ready = 1'b0;
            default: begin
                if (xfer_now) begin
                    book_ready = 1'b1;
                    ph = $urandom_range(3, 1);
                end else if (ph > 0) begin
                    book_ready = 1'b0;
                    ph--;
                end else begin
                    book_ready = ($urandom_range(3, 0) != 0);
                end
            end
        endcase
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] id,
                        input logic [31:0] qty, input logic [63:0] pr);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_cmd = c;
        in_order_id = id;
        in_quantity = qty;
        in_price = pr;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (push_ok) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            cycle();
            n++;
        end
        check("drain_done", {busy, exp_q.size() != 0}, 0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_issued"}, issued_count, exp_issued);
        check({tag, "_dropped"}, dropped_count, exp_dropped);
        check({tag, "_timeout"}, timeout_count, exp_timeout);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_issued = 0;
        exp_dropped = 0;
        exp_timeout = 0;
        prev_stall = 1'b0;
        last_xfer = -100;
        ph = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int acc;
        int x0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_book_valid", book_valid, 0);
        check("rst_req_type", book_req_type, 0);
        check("rst_order_id", book_order_id, 0);
        check("rst_quantity", book_quantity, 0);
        check("rst_price", book_price, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check_counters("rst");
        reset = 1'b0;
        cycle();
        check("in_ready_after_rst", in_ready, 1);

        // Single ADD with a realistic book
        push(2'd0, 32'd5, 32'd100, 64'h1F4);
        drain();
        check("t1_xfers", n_xfer, 1);
        check("t1_busy", busy, 0);
        check_counters("t1");

        // Illegal command is counted and never reaches the FIFO
        push(2'd3, 32'd9, 32'd1, 64'd1);
        check("t3_busy", busy, 0);
        check("t3_dropped", dropped_count, 1);
        repeat (4) cycle();
        check("t3_xfers", n_xfer, 1);

        // CANCEL then DECREASE on the same order
        push(2'd1, 32'd7, 32'd55, 64'hDEAD);
        push(2'd2, 32'd7, 32'd30, 64'hBEEF);
        drain();
        check_counters("t5");

        // Book stalled: one command sits in ISSUE, DEPTH more fill the FIFO
        mode = MODE_STALL;
        book_ready = 1'b0;
        acc = 0;
        x0 = n_xfer;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_cmd = 2'(acc % 3);
            in_order_id = 32'd100 + 32'(acc);
            in_quantity = $urandom;
            in_price = {$urandom, $urandom};
            cycle();
            if (push_ok) acc++;
            if (!in_ready) break;
        end
        in_valid = 1'b0;
        check("t2_accepted", acc, DEPTH + 1);
        check("t2_in_ready", in_ready, 0);
        check("t2_valid", book_valid, 1);
        repeat (5) cycle();
        mode = MODE_REAL;
        book_ready = 1'b1;
        drain();
        check("t2_xfers", n_xfer - x0, DEPTH + 1);
        check_counters("t2");

        // book_ready stuck high: every command ends in a busy timeout
        mode = MODE_ALWAYS;
        book_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            push(2'($urandom_range(2, 0)), $urandom, $urandom, {$urandom, $urandom});
        drain();
        exp_timeout += 4;
        check_counters("t4");

        // Random traffic with a realistic book
        mode = MODE_REAL;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(2, 0) == 0);
            in_cmd = 2'($urandom_range(3, 0));
            in_order_id = $urandom;
            in_quantity = $urandom;
            in_price = {$urandom, $urandom};
            cycle();
        end
        in_valid = 1'b0;
        drain();
        check_counters("rand");

        // Reset while a command is being offered with more queued behind it
        mode = MODE_STALL;
        book_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(2'd0, 32'd200 + 32'(i), 32'd1, 64'd2);
        repeat (2) cycle();
        check("t6_valid_before", book_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid_in_rst", book_valid, 0);
        check("t6_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mode = MODE_REAL;
        book_ready = 1'b1;
        cycle();
        check("t6_in_ready", in_ready, 1);
        check("t6_busy", busy, 0);
        check_counters("t6");
        push(2'd0, 32'd42, 32'd8, 64'd99);
        drain();
        check_counters("t6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
